mem_fill_responder: RTL and testbench

//  Memory-side responder for the cache/memory interface: services line-fill reads and write-through stores.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_fill_responder_if.sv | 19 +
 rtl/mem_word_array.sv | 23 ++
 rtl/mem_fill_responder.sv | 123 ++++++++++++
 tb/tb_mem_fill_responder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the cache/memory fill interface.
// Line geometry is shared with the I- and D-cache miss controllers.
package mem_pkg;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int BURST_LEN  = 8;
  localparam int LAT_DEF    = 4;
  localparam int BEAT_W     = $clog2(BURST_LEN);
  localparam int LINE_OFF_W = BEAT_W + 1;
  localparam int WIDX_W     = ADDR_W - 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_e;

  typedef struct packed {
    logic [WIDX_W-1:0] widx;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Word index of the first word of the line containing byte address a.
  function automatic logic [WIDX_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFF_W], {BEAT_W{1'b0}}};
  endfunction
endpackage

// File: rtl/mem_fill_responder_if.sv
// Request/response bus between the miss arbiter (master) and the memory responder (slave).
interface mem_fill_responder_if;
  import mem_pkg::*;
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_last;
  logic              wr_ack;

  modport master (output req_valid, req_wr, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_data, resp_addr, resp_last, wr_ack);
  modport slave  (input  req_valid, req_wr, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_data, resp_addr, resp_last, wr_ack);
endinterface

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port, one synchronous read port, contents not reset.
module mem_word_array #(
  parameter int DEPTH = 32768,
  parameter int AW    = 15,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_fill_responder.sv
// Multi-cycle main-memory model: fixed-latency line fills returned one word per cycle,
// and write-through single-word stores acknowledged after the same latency.
module mem_fill_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_fill_responder_if.slave  bus
);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << WIDX_W;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d, next_beat, rd_beat;
  mem_req_t          lat_q, lat_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_last_q, resp_last_d;
  logic              wr_ack_q, wr_ack_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic              mem_we;
  logic [WIDX_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = bus.req_addr[0];
  assign next_beat = beat_q + 1'b1;
  // Read port runs one word ahead of the output so data lands with its resp_valid cycle.
  assign rd_beat   = (state_q == RD_BURST) ? next_beat : '0;
  assign mem_raddr = {lat_q.widx[WIDX_W-1:BEAT_W], rd_beat};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    lat_d        = lat_q;
    resp_valid_d = 1'b0;
    resp_last_d  = 1'b0;
    resp_addr_d  = '0;
    wr_ack_d     = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        lat_d.widx  = bus.req_wr ? bus.req_addr[ADDR_W-1:1] : line_base(bus.req_addr);
        lat_d.wdata = bus.req_wdata;
        cnt_d       = CNT_W'(1);
        beat_d      = '0;
        state_d     = bus.req_wr ? WR_WAIT : RD_WAIT;
      end
      RD_WAIT: if (cnt_q == CNT_LAST) begin
        state_d      = RD_BURST;
        cnt_d        = '0;
        resp_valid_d = 1'b1;
        resp_addr_d  = {lat_q.widx, 1'b0};
        resp_last_d  = (BURST_LEN == 1);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RD_BURST: begin
        beat_d = next_beat;
        if (beat_q == BEAT_LAST) begin
          state_d = IDLE;
        end else begin
          resp_valid_d = 1'b1;
          resp_addr_d  = {lat_q.widx[WIDX_W-1:BEAT_W], next_beat, 1'b0};
          resp_last_d  = (next_beat == BEAT_LAST);
        end
      end
      WR_WAIT: if (cnt_q == CNT_LAST) begin
        mem_we   = 1'b1;
        wr_ack_d = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      lat_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_addr_q  <= '0;
      wr_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      lat_q        <= lat_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_addr_q  <= resp_addr_d;
      wr_ack_q     <= wr_ack_d;
    end
  end

  mem_word_array #(.DEPTH(DEPTH), .AW(WIDX_W), .DW(DATA_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (lat_q.widx),
    .wdata_i (lat_q.wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  // Array output is unreset, so gate it to keep the bus quiet outside bursts and in reset.
  assign bus.resp_data  = resp_valid_q ? mem_rdata : '0;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_last  = resp_last_q;
  assign bus.wr_ack     = wr_ack_q;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Randomized bench for mem_fill_responder against a word-array reference model.
module tb_mem_fill_responder;
  import mem_pkg::*;
  localparam int LAT = 4;
  localparam int BL  = BURST_LEN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_fill_responder_if bus();
  mem_fill_responder #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errs = 0;
  int checks = 0;
  logic [DATA_W-1:0] mdl [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_rdy"}, bus.req_ready, 1);
    chk({tag, "_vld"}, bus.resp_valid, 0);
    chk({tag, "_dat"}, bus.resp_data, 0);
    chk({tag, "_lst"}, bus.resp_last, 0);
    chk({tag, "_ack"}, bus.wr_ack, 0);
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] data);
    @(posedge clk) #1;
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = data;
    @(negedge clk);
    chk("c0_rdy", bus.req_ready, 1);
    chk("c0_ack", bus.wr_ack, 0);
    chk("c0_vld", bus.resp_valid, 0);
  endtask

  // Checks cycles 1..LAT+BL of a read already accepted; optionally holds a follow-on request.
  task automatic run_read(input logic [15:0] addr, input bit hold, input logic [15:0] haddr);
    logic [15:0] base;
    int k;
    base = {addr[15:4], 4'h0};
    for (int c = 1; c <= LAT + BL; c++) begin
      @(posedge clk) #1;
      if (c == 1) begin
        bus.req_valid = hold;
        bus.req_wr    = hold ? 1'b0 : 1'($urandom);
        bus.req_addr  = hold ? haddr : 16'($urandom);
        bus.req_wdata = 16'($urandom);
      end
      @(negedge clk);
      if (c < LAT) begin
        chk("rw_vld", bus.resp_valid, 0);
        chk("rw_rdy", bus.req_ready, 0);
        chk("rw_dat", bus.resp_data, 0);
      end else if (c < LAT + BL) begin
        k = c - LAT;
        chk("rb_vld", bus.resp_valid, 1);
        chk("rb_rdy", bus.req_ready, 0);
        chk("rb_adr", bus.resp_addr, base + 16'(2 * k));
        chk("rb_dat", bus.resp_data, mdl[int'(base >> 1) + k]);
        chk("rb_lst", bus.resp_last, (k == BL - 1));
      end else begin
        chk("re_rdy", bus.req_ready, 1);
        chk("re_vld", bus.resp_valid, 0);
        chk("re_lst", bus.resp_last, 0);
      end
    end
  endtask

  task automatic do_read(input logic [15:0] addr);
    issue(1'b0, addr, 16'($urandom));
    run_read(addr, 1'b0, 16'h0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    issue(1'b1, addr, data);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk) #1;
      if (c == 1) begin
        bus.req_valid = 1'b0; bus.req_addr = 16'($urandom); bus.req_wdata = 16'($urandom);
      end
      @(negedge clk);
      chk("w_vld", bus.resp_valid, 0);
      chk("w_ack", bus.wr_ack, (c == LAT));
      chk("w_rdy", bus.req_ready, (c == LAT));
    end
    mdl[int'(addr >> 1)] = data;
  endtask

  task automatic preload(input logic [15:0] base, input bit rnd);
    for (int k = 0; k < BL; k++)
      do_write(base + 16'(2 * k), rnd ? 16'($urandom) : 16'h1000 + 16'(k));
  endtask

  // Assert reset asynchronously after the given cycle of a just-issued request.
  task automatic abort_at(input int cyc, input bit expect_vld);
    for (int c = 1; c <= cyc; c++) begin
      @(posedge clk) #1;
      if (c == 1) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    chk("ab_pre_vld", bus.resp_valid, expect_vld);
    #2 rst = 1'b1;
    #1;
    idle_chk("ab_async");
    chk("ab_adr", bus.resp_addr, 0);
    @(posedge clk) #1 rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      idle_chk("ab_after");
    end
  endtask

  logic [15:0] pool [6] = '{16'h0040, 16'h0100, 16'h0200, 16'hFFF0, 16'h1230, 16'h8000};

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    #3;
    idle_chk("rst");
    chk("rst_adr", bus.resp_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_chk("idle");

    preload(16'h0040, 1'b0);
    do_read(16'h0046);

    preload(16'h0100, 1'b1);
    do_write(16'h0102, 16'hBEEF);
    do_read(16'h0100);

    // Follow-on request held through the burst must be taken at the first ready cycle.
    issue(1'b0, 16'h0040, 16'h0);
    run_read(16'h0040, 1'b1, 16'h0106);
    run_read(16'h0106, 1'b0, 16'h0);

    preload(16'h0200, 1'b1);
    issue(1'b0, 16'h0200, 16'h0);
    abort_at(6, 1'b1);
    issue(1'b1, 16'h0200, 16'hDEAD);
    abort_at(2, 1'b0);
    do_read(16'h0200);

    preload(16'hFFF0, 1'b1);
    do_read(16'hFFFF);

    preload(16'h1230, 1'b1);
    preload(16'h8000, 1'b1);
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      a = pool[$urandom_range(0, 5)] | 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom));
      else do_read(a);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1, "timeout");
  end
endmodule
